// File: rtl/dft_obs_hold_sched.sv
// dft_obs_hold_sched
//   Round-robin scheduler for groups of DFT observation hold cells. Every group's HOLD line
//   idles high (value frozen). On request, one group at a time gets a capture window of
//   CAP_CYC cycles with HOLD low. HOLD then returns high and a one-cycle ACK is issued.
//   SETTLE_CYC idle cycles follow before the next arbitration.
//
// Ports
//   i_cp       clock, all state changes on the rising edge
//   i_rn       synchronous active-low reset
//   i_enable   1 = new grants allowed
//   i_req      per-group level request, held by the requester until its ACK
//   o_hold     per-group hold control, 1 = hold, 0 = capture
//   o_ack      per-group one-cycle pulse at the end of that group's capture window
//   o_busy     1 while the scheduler is not idle
//   o_cur_grp  index of the most recently granted group
module dft_obs_hold_sched #(
    parameter int unsigned NGRP       = 4,
    parameter int unsigned CAP_CYC    = 1,
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned IDXW       = 2
) (
    input  logic            i_cp,
    input  logic            i_rn,
    input  logic            i_enable,
    input  logic [NGRP-1:0] i_req,
    output logic [NGRP-1:0] o_hold,
    output logic [NGRP-1:0] o_ack,
    output logic            o_busy,
    output logic [IDXW-1:0] o_cur_grp
);

    localparam int unsigned CNT_MAX = (CAP_CYC > SETTLE_CYC) ? CAP_CYC : SETTLE_CYC;
    localparam int unsigned CNTW    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StSettle
    } state_e;

    state_e          r_state;
    logic [CNTW-1:0] r_cnt;
    logic [IDXW-1:0] r_ptr;
    logic [NGRP-1:0] r_hold;
    logic [NGRP-1:0] r_ack;
    logic            r_busy;
    logic [IDXW-1:0] r_cur_grp;

    logic            w_found;
    logic [IDXW-1:0] w_sel;
    logic [IDXW-1:0] w_try;
    logic [IDXW-1:0] w_ptr_nxt;

    // Scan requests starting at the round-robin pointer, wrapping at NGRP; first hit wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_try   = '0;
        for (int unsigned i = 0; i < NGRP; i++) begin
            w_try = IDXW'((32'(r_ptr) + i) % NGRP);
            if (!w_found && i_req[w_try]) begin
                w_found = 1'b1;
                w_sel   = w_try;
            end
        end
        w_ptr_nxt = IDXW'((32'(w_sel) + 32'd1) % NGRP);
    end

    always_ff @(posedge i_cp) begin
        if (!i_rn) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_ptr     <= '0;
            r_hold    <= '1;
            r_ack     <= '0;
            r_busy    <= 1'b0;
            r_cur_grp <= '0;
        end else begin
            r_ack <= '0;
            unique case (r_state)
                StIdle: begin
                    if (i_enable && w_found) begin
                        r_hold    <= ~(NGRP'(1) << w_sel);
                        r_cur_grp <= w_sel;
                        r_ptr     <= w_ptr_nxt;
                        r_cnt     <= CNTW'(CAP_CYC - 1);
                        r_state   <= StCapture;
                        r_busy    <= 1'b1;
                    end
                end
                StCapture: begin
                    if (r_cnt == '0) begin
                        // The single low HOLD bit marks the group to acknowledge.
                        r_ack  <= ~r_hold;
                        r_hold <= '1;
                        if (SETTLE_CYC > 0) begin
                            r_cnt   <= CNTW'(SETTLE_CYC - 1);
                            r_state <= StSettle;
                        end else begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StSettle: begin
                    if (r_cnt == '0) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_hold  <= '1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_hold    = r_hold;
    assign o_ack     = r_ack;
    assign o_busy    = r_busy;
    assign o_cur_grp = r_cur_grp;

endmodule
